// File: rtl/lag_window_pkg.sv
// Shared constants, state encoding and fixed-point helpers for the lag window.
// Provides the Mpy_32 / mult / saturation arithmetic used on r[i].
package lag_window_pkg;

    localparam logic [11:0] AUTOCORR_R   = 12'h100;
    localparam logic [11:0] LAG_WINDOW_R = 12'h140;

    localparam logic signed [31:0] MAX_32 = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] MIN_32 = 32'sh8000_0000;
    localparam logic signed [15:0] MAX_16 = 16'sh7FFF;
    localparam logic signed [15:0] MIN_16 = 16'sh8000;

    localparam logic [3:0] LAST_IDX = 4'd10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        LATCH = 3'd2,
        MUL   = 3'd3,
        WR    = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Clamp a 34-bit intermediate sum to the signed 32-bit range.
    function automatic logic signed [31:0] sat32(input logic signed [33:0] x);
        if (x[33:31] == 3'b000 || x[33:31] == 3'b111)
            return x[31:0];
        else
            return x[33] ? MIN_32 : MAX_32;
    endfunction

    function automatic logic signed [15:0] mult16(input logic signed [15:0] a,
                                                  input logic signed [15:0] b);
        logic signed [31:0] p;
        p = (32'(a) * 32'(b)) >>> 15;
        if (p[31:15] == 17'h0_0000 || p[31:15] == 17'h1_FFFF)
            return p[15:0];
        else
            return p[31] ? MIN_16 : MAX_16;
    endfunction

    function automatic logic signed [31:0] mpy32(input logic signed [15:0] hi1,
                                                 input logic signed [15:0] lo1,
                                                 input logic signed [15:0] hi2,
                                                 input logic signed [15:0] lo2);
        logic signed [33:0] t;
        logic signed [31:0] acc;
        logic signed [15:0] m;
        t   = (34'(hi1) * 34'(hi2)) <<< 1;
        acc = sat32(t);
        m   = mult16(hi1, lo2);
        t   = 34'(acc) + (34'(m) <<< 1);
        acc = sat32(t);
        m   = mult16(lo1, hi2);
        t   = 34'(acc) + (34'(m) <<< 1);
        acc = sat32(t);
        return acc;
    endfunction

endpackage

// File: rtl/lag_window_rom.sv
// Lag-window coefficient table, split into high and low 16-bit halves.
// Combinational lookup; indices outside 0..9 return zero.
module lag_wind_rom
    import lag_window_pkg::*;
(
    input  logic        [3:0]  index,
    output logic signed [15:0] lag_h,
    output logic signed [15:0] lag_l
);

    always_comb begin
        lag_h = 16'sd0;
        lag_l = 16'sd0;
        case (index)
            4'd0: begin lag_h = 16'sd32728; lag_l = 16'sd11904; end
            4'd1: begin lag_h = 16'sd32619; lag_l = 16'sd17280; end
            4'd2: begin lag_h = 16'sd32438; lag_l = 16'sd30720; end
            4'd3: begin lag_h = 16'sd32187; lag_l = 16'sd25856; end
            4'd4: begin lag_h = 16'sd31867; lag_l = 16'sd24192; end
            4'd5: begin lag_h = 16'sd31480; lag_l = 16'sd28992; end
            4'd6: begin lag_h = 16'sd31029; lag_l = 16'sd24384; end
            4'd7: begin lag_h = 16'sd30517; lag_l = 16'sd7360;  end
            4'd8: begin lag_h = 16'sd29946; lag_l = 16'sd19520; end
            4'd9: begin lag_h = 16'sd29321; lag_l = 16'sd14784; end
            default: begin lag_h = 16'sd0; lag_l = 16'sd0; end
        endcase
    end

endmodule

// File: rtl/lag_window.sv
// Applies the lag window to r[0..10] in scratch memory, one word per 4 cycles.
// Define LAG_WINDOW_INPLACE_EN to write results back over the autocorrelation input.
module lag_window
    import lag_window_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] memOut,
    output logic [11:0] memReadAddr,
    output logic [11:0] memWriteAddr,
    output logic [31:0] memIn,
    output logic        memWrite,
    output logic        done
);

`ifdef LAG_WINDOW_INPLACE_EN
    localparam logic [11:0] OUT_BASE = AUTOCORR_R;
`else
    localparam logic [11:0] OUT_BASE = LAG_WINDOW_R;
`endif

    state_t             state_q, state_d;
    logic        [3:0]  idx_q, idx_d;
    logic signed [31:0] r_q, r_d;
    logic        [31:0] memIn_q, memIn_d;
    logic        [11:0] rdAddr_q, rdAddr_d;
    logic        [11:0] wrAddr_q, wrAddr_d;
    logic               memWrite_q, memWrite_d;
    logic               done_q, done_d;

    logic signed [15:0] lagH, lagL;
    logic signed [15:0] rHi, rLo;
    logic signed [31:0] rLoWide;
    logic signed [31:0] result;

    lag_wind_rom u_rom (
        .index (idx_q - 4'd1),
        .lag_h (lagH),
        .lag_l (lagL)
    );

    // L_Extract split of the latched word, then the windowed product.
    always_comb begin
        rHi     = r_q[31:16];
        rLoWide = (r_q >>> 1) - (32'(rHi) <<< 15);
        rLo     = rLoWide[15:0];
        result  = (idx_q == 4'd0) ? r_q : mpy32(rHi, rLo, lagH, lagL);
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        r_d      = r_q;
        memIn_d  = memIn_q;
        rdAddr_d = rdAddr_q;
        wrAddr_d = wrAddr_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RD;
                    idx_d    = 4'd0;
                    rdAddr_d = AUTOCORR_R;
                end
            end
            RD:    state_d = LATCH;
            LATCH: begin
                r_d     = memOut;
                state_d = MUL;
            end
            MUL: begin
                memIn_d  = result;
                wrAddr_d = OUT_BASE + {8'd0, idx_q};
                state_d  = WR;
            end
            WR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    state_d  = RD;
                    idx_d    = idx_q + 4'd1;
                    rdAddr_d = AUTOCORR_R + {8'd0, idx_q + 4'd1};
                end
            end
            default: state_d = IDLE;
        endcase
        memWrite_d = (state_d == WR);
        // done lags entry into DONE by one edge and drops on the restarting edge.
        done_d     = (state_q == DONE) && (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= 4'd0;
            r_q        <= 32'sd0;
            memIn_q    <= 32'd0;
            rdAddr_q   <= 12'd0;
            wrAddr_q   <= 12'd0;
            memWrite_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            r_q        <= r_d;
            memIn_q    <= memIn_d;
            rdAddr_q   <= rdAddr_d;
            wrAddr_q   <= wrAddr_d;
            memWrite_q <= memWrite_d;
            done_q     <= done_d;
        end
    end

    assign memReadAddr  = rdAddr_q;
    assign memWriteAddr = wrAddr_q;
    assign memIn        = memIn_q;
    assign memWrite     = memWrite_q;
    assign done         = done_q;

endmodule

// File: tb/tb_lag_window.sv
// Scoreboard bench for lag_window: directed r[] vectors with hand-computed results.
// Honours LAG_WINDOW_INPLACE_EN for the expected write base address.
module tb_lag_window;
    import lag_window_pkg::*;

`ifdef LAG_WINDOW_INPLACE_EN
    localparam logic [11:0] OUT_BASE = AUTOCORR_R;
`else
    localparam logic [11:0] OUT_BASE = LAG_WINDOW_R;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] memOut;
    logic [11:0] memReadAddr;
    logic [11:0] memWriteAddr;
    logic [31:0] memIn;
    logic        memWrite;
    logic        done;

    lag_window dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .memOut       (memOut),
        .memReadAddr  (memReadAddr),
        .memWriteAddr (memWriteAddr),
        .memIn        (memIn),
        .memWrite     (memWrite),
        .done         (done)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] R_IN [11] = '{
        32'h7FFFFFFF, 32'h40000000, 32'hC0000000, 32'h00000000,
        32'h7FFF0000, 32'h80000000, 32'h0000FFFE, 32'hFFFF0000,
        32'h0002FFFE, 32'hFFFFFFFF, 32'h7FFFFFFF };
    localparam logic [31:0] R_EXP [11] = '{
        32'h7FFFFFFF, 32'h3FEC2E80, 32'hC04A3C80, 32'h00000000,
        32'h7DBACE88, 32'h83844300, 32'h0000F5EE, 32'hFFFF0D94,
        32'h0002CB3C, 32'hFFFFFFFC, 32'h7289737C };

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] mem [0:4095];
    int          cycleCount = 0;
    int          testsRun = 0;
    int          testsFailed = 0;
    int          startEdge = 0;

    always @(posedge clk) begin
        cycleCount <= cycleCount + 1;
        memOut <= mem[memReadAddr];
        if (memWrite === 1'b1)
            mem[memWriteAddr] <= memIn;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)",
                     name, actual, expected, cycleCount);
        end
    endtask

    // Monitor: every observed write is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (memWrite === 1'b1) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpectedWrite: addr %h data %h at cycle %0d, expected no write",
                         memWriteAddr, memIn, cycleCount);
            end else begin
                e = expQ.pop_front();
                checkOutput("writeAddr", {20'd0, memWriteAddr}, {20'd0, e.addr});
                checkOutput("writeData", memIn, e.data);
                checkOutput("writeCycle", 32'(cycleCount), 32'(e.cyc));
            end
        end
    end

    task automatic loadInputs();
        for (int i = 0; i < 11; i++)
            mem[AUTOCORR_R + 12'(i)] = R_IN[i];
    endtask

    task automatic waitUntil(input int target);
        while (cycleCount < target) @(negedge clk);
    endtask

    task automatic applyStimulus(input int nWords);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        startEdge = cycleCount + 1;
        for (int k = 0; k < nWords; k++) begin
            e.addr = OUT_BASE + 12'(k);
            e.data = R_EXP[k];
            e.cyc  = startEdge + 4 * k + 3;
            expQ.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'hDEADBEEF;
        loadInputs();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetMemWrite", {31'd0, memWrite}, 32'd0);
        checkOutput("resetDone", {31'd0, done}, 32'd0);
        checkOutput("resetReadAddr", {20'd0, memReadAddr}, 32'd0);
        checkOutput("resetWriteAddr", {20'd0, memWriteAddr}, 32'd0);
        checkOutput("resetMemIn", memIn, 32'd0);

        // start coinciding with reset must be dropped
        start = 1'b1;
        @(negedge clk);
        checkOutput("resetPrioReadAddr", {20'd0, memReadAddr}, 32'd0);
        start = 1'b0;
        reset = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("idleDone", {31'd0, done}, 32'd0);

        // full pass with a stray start at cycle 20
        applyStimulus(11);
        waitUntil(startEdge + 19);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitUntil(startEdge + 44);
        checkOutput("doneBeforeEdge45", {31'd0, done}, 32'd0);
        @(negedge clk);
        checkOutput("doneAtEdge45", {31'd0, done}, 32'd1);
        repeat (6) @(negedge clk);
        checkOutput("doneHeld", {31'd0, done}, 32'd1);
        checkOutput("pass1Drained", 32'(expQ.size()), 32'd0);
        checkOutput("pass1Word1Mem", mem[OUT_BASE + 12'd1], R_EXP[1]);

        // restart from DONE, then reset at cycle 17
        loadInputs();
        applyStimulus(4);
        checkOutput("doneClearedOnRestart", {31'd0, done}, 32'd0);
        waitUntil(startEdge + 16);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abortMemWrite", {31'd0, memWrite}, 32'd0);
        checkOutput("abortDone", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("abortDrained", 32'(expQ.size()), 32'd0);
        checkOutput("abortDoneLow", {31'd0, done}, 32'd0);

        // clean pass after the abort
        loadInputs();
        applyStimulus(11);
        waitUntil(startEdge + 45);
        checkOutput("pass3Done", {31'd0, done}, 32'd1);
        checkOutput("pass3Drained", 32'(expQ.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/lag_window.md
LAG_WINDOW -- requirements
Module: lag_window

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all logic on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: one-cycle pulse that begins a pass over r[0..10].
REQ-004 SHALL have port memOut, input, 32 bits: scratch-memory read data, valid one cycle after memReadAddr.
REQ-005 SHALL have port memReadAddr, output, 12 bits: scratch-memory read address.
REQ-006 SHALL have port memWriteAddr, output, 12 bits: scratch-memory write address.
REQ-007 SHALL have port memIn, output, 32 bits: scratch-memory write data.
REQ-008 SHALL have port memWrite, output, 1 bit: write strobe.
REQ-009 SHALL have port done, output, 1 bit: pass complete.

Function
REQ-010 SHALL read r[i] (i = 0..10) from AUTOCORR_R+i and write r'[i] to LAG_WINDOW_R+i.
REQ-011 SHALL pass r'[0] = r[0] unchanged.
REQ-012 SHALL compute r'[i] for i = 1..10 as Mpy_32(r_h, r_l, lag_h[i-1], lag_l[i-1]), using the L_Extract split:
  - r_h = r[31:16];
  - r_l = ((r>>>1) - (r_h<<15))[15:0].
REQ-013 SHALL evaluate Mpy_32 as sat32(2*r_h*lag_h) + 2*mult(r_h, lag_l) + 2*mult(r_l, lag_h):
  - mult(a,b) = sat16((a*b)>>>15);
  - each addition saturates to 32 bits;
  - all operands are signed.
REQ-014 SHALL use a state machine with states IDLE, RD, LATCH, MUL, WR, DONE:
  - IDLE->RD on start;
  - RD drives memReadAddr;
  - LATCH captures memOut;
  - MUL registers the result;
  - WR asserts memWrite for exactly one cycle;
  - after WR: RD if i<10, else DONE.
REQ-015 SHALL complete in fixed latency: 4 cycles per word, 44 cycles total; done rises on the 45th rising edge after start is sampled.
REQ-016 SHALL hold done high in DONE until the next start, which clears done and restarts at i=0.
REQ-017 SHALL ignore start while in RD, LATCH, MUL or WR.
REQ-018 SHALL hold memWrite low in every state except WR; memIn and memWriteAddr are don't-care when memWrite=0.
REQ-019 SHALL use a 4-bit index counter; values above 10 are unreachable.

Reset
REQ-020 SHALL, on reset, force state=IDLE, i=0, done=0, memWrite=0, memReadAddr=0, memWriteAddr=0, memIn=0.
REQ-021 SHALL, on reset asserted mid-pass, abort with no further write; the partial output is discarded.
REQ-022 SHALL give reset priority over a simultaneous start.

Configuration
REQ-023 SHALL support macro LAG_WINDOW_INPLACE_EN:
  - defined: r'[i] is written back to AUTOCORR_R+i, overwriting the input;
  - undefined: r'[i] is written to LAG_WINDOW_R+i and AUTOCORR_R is never written.
  Latency is identical in both builds.

Structure
REQ-024 SHALL take AUTOCORR_R, LAG_WINDOW_R, the state encodings and the constants MAX_32/MIN_32/MAX_16/MIN_16 from the shared paramList.v.
REQ-025 SHALL hold the lag table in sub-module lag_wind_rom: 4-bit index, combinational 16-bit lag_h and lag_l outputs.
  - lag_h = {32728, 32619, 32438, 32187, 31867, 31480, 31029, 30517, 29946, 29321};
  - lag_l = {11904, 17280, 30720, 25856, 24192, 28992, 24384, 7360, 19520, 14784}.

Verification
REQ-026 SHALL cover passthrough: r[0]=0x7FFFFFFF -> LAG_WINDOW_R+0 written 0x7FFFFFFF.
REQ-027 SHALL cover a positive coefficient: r[1]=0x40000000 -> r'[1]=0x3FEC2E80.
REQ-028 SHALL cover a negative coefficient: r[2]=0xC0000000 -> r'[2]=0xC04A3C80.
REQ-029 SHALL cover timing: start pulse -> exactly 11 memWrite pulses, 4 cycles apart, at ascending addresses; done high on cycle 45 and held; a start at cycle 20 is ignored.
REQ-030 SHALL cover reset mid-pass: reset at cycle 17 -> memWrite=0 from the next edge, done=0, no further writes; a new start then completes all 11 words correctly.
REQ-031 SHALL cover regression: 120 frames of ITU G.729 lag-window vectors (lsp_autocorr_out as input) -> all 1320 words bit-exact, in both LAG_WINDOW_INPLACE_EN builds.
